// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles the core-side request/response handshake and the
//                word-wide data-memory req/gnt/rvalid bus of the load/store
//                unit.
//                slave  modport : the load/store unit's view.
//                master modport : the environment's view (core + memory).
//  Signals     : req_valid_i/req_ready_o/req_we_i/req_func3_i/req_addr_i/
//                req_wdata_i  - core request
//                rsp_valid_o/rsp_rdata_o/rsp_err_o/stall_o - core response
//                mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o/
//                mem_gnt_i/mem_rvalid_i/mem_rdata_i - data memory bus
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_func3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle RV32I load/store unit. Accepts one access at a
//                time from the core, checks funct3/alignment legality, drives
//                a word-wide memory with req/gnt/rvalid handshake, aligns
//                store data into byte lanes, extracts and extends load lanes
//                and times out a silent memory. Stalls the core meanwhile.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - synchronous reset, active-high
//                bus    - load_store_unit_if.slave (core + memory signals)
//  Parameters  : TIMEOUT - WAIT cycles without rvalid before error (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t             state;
    logic               we_q;
    logic [2:0]         func3_q;
    logic [1:0]         lane_q;
    logic [CNT_W-1:0]   cnt;

    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_be_q;

    logic               legal;
    logic [3:0]         store_be;
    logic [31:0]        store_wdata;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [31:0]        load_data;

    // Request legality: funct3 encoding for the direction plus natural alignment.
    always_comb begin
        legal = 1'b0;
        case (bus.req_func3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~bus.req_addr_i[0];
            3'b010:  legal = (bus.req_addr_i[1:0] == 2'b00);
            3'b100:  legal = ~bus.req_we_i;
            3'b101:  legal = ~bus.req_we_i & ~bus.req_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    // Store lanes: data is replicated so the selected byte enables pick it up.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = bus.req_wdata_i;
        case (bus.req_func3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << bus.req_addr_i[1:0];
                store_wdata = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                store_be    = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{bus.req_wdata_i[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = bus.req_wdata_i;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the captured request.
    always_comb begin
        case (lane_q)
            2'd0:    load_byte = bus.mem_rdata_i[7:0];
            2'd1:    load_byte = bus.mem_rdata_i[15:8];
            2'd2:    load_byte = bus.mem_rdata_i[23:16];
            default: load_byte = bus.mem_rdata_i[31:24];
        endcase
        load_half = lane_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (func3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = bus.mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            func3_q     <= 3'd0;
            lane_q      <= 2'd0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (bus.req_valid_i) begin
                        we_q    <= bus.req_we_i;
                        func3_q <= bus.req_func3_i;
                        lane_q  <= bus.req_addr_i[1:0];
                        if (legal) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_we_i;
                            mem_addr_q  <= {bus.req_addr_i[31:2], 2'b00};
                            mem_be_q    <= bus.req_we_i ? store_be : 4'b1111;
                            mem_wdata_q <= bus.req_we_i ? store_wdata : 32'd0;
                            state       <= S_REQ;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            state       <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= 32'd0;
                            state       <= S_RESP;
                        end else begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // rvalid takes priority over an expiring timeout.
                    if (bus.mem_rvalid_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_data;
                        state       <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state == S_IDLE);
    assign bus.stall_o     = ((state == S_IDLE) && bus.req_valid_i) ||
                             (state == S_REQ) || (state == S_WAIT);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_be_o    = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit: reset,
//                store lane alignment, load extension, illegal accesses,
//                delayed grant, timeout, rvalid/timeout race and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_func3_i = f3;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_func3_i = 3'd0;
        bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'd0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); end
        checks++; if (bus.mem_be_o !== 4'd0) begin errors++; $display("FAIL reset_mem_be: got %b expected 0000", bus.mem_be_o); end
        checks++; if (bus.rsp_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rsp_rdata_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
    endtask

    // Store with immediate grant; checks the memory-side lane image.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        issue(1'b1, f3, addr, wdata);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL st_stall_accept: got %b expected 1", bus.stall_o); end
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL st_mem_req: got %b expected 1", bus.mem_req_o); end
        checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL st_mem_we: got %b expected 1", bus.mem_we_o); end
        checks++; if (bus.mem_addr_o !== exp_addr) begin errors++; $display("FAIL st_mem_addr: got %h expected %h", bus.mem_addr_o, exp_addr); end
        checks++; if (bus.mem_be_o !== exp_be) begin errors++; $display("FAIL st_mem_be: got %b expected %b", bus.mem_be_o, exp_be); end
        checks++; if (bus.mem_wdata_o !== exp_wdata) begin errors++; $display("FAIL st_mem_wdata: got %h expected %h", bus.mem_wdata_o, exp_wdata); end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL st_rsp_valid_cycle2: got %b expected 1", bus.rsp_valid_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL st_rsp_err: got %b expected 0", bus.rsp_err_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL st_mem_req_drop: got %b expected 0", bus.mem_req_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL st_stall_resp: got %b expected 0", bus.stall_o); end
        tick();
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL st_rsp_pulse: got %b expected 0", bus.rsp_valid_o); end
    endtask

    task automatic test_stores();
        run_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        run_store(3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        run_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
        run_store(3'b001, 32'h0000_0200, 32'h0000_CAFE, 32'h0000_0200, 4'b0011, 32'hCAFE_CAFE);
    endtask

    // Load with immediate grant and rvalid in the following cycle.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'd0);
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.mem_be_o !== 4'b1111 || bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL ld_be_we: got be=%b we=%b expected be=1111 we=0", bus.mem_be_o, bus.mem_we_o); end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b1) begin errors++; $display("FAIL ld_wait: got req=%b stall=%b expected req=0 stall=1", bus.mem_req_o, bus.stall_o); end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rdata;
        tick();
        bus.mem_rvalid_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL ld_rsp_cycle3: got valid=%b err=%b expected valid=1 err=0", bus.rsp_valid_o, bus.rsp_err_o); end
        checks++; if (bus.rsp_rdata_o !== exp) begin errors++; $display("FAIL ld_rdata f3=%b addr=%h: got %h expected %h", f3, addr, bus.rsp_rdata_o, exp); end
        tick();
    endtask

    task automatic test_loads();
        run_load(3'b000, 32'h0000_0101, 32'h1234_8000, 32'hFFFF_FF80);
        run_load(3'b100, 32'h0000_0101, 32'h1234_8000, 32'h0000_0080);
        run_load(3'b001, 32'h0000_0102, 32'h8001_1234, 32'hFFFF_8001);
        run_load(3'b101, 32'h0000_0102, 32'h8001_1234, 32'h0000_8001);
        run_load(3'b000, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F);
        run_load(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic run_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        issue(we, f3, addr, 32'h1111_1111);
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1) begin errors++; $display("FAIL ill_rsp_cycle1 f3=%b addr=%h: got valid=%b err=%b expected 1 1", f3, addr, bus.rsp_valid_o, bus.rsp_err_o); end
        checks++; if (bus.rsp_rdata_o !== 32'd0) begin errors++; $display("FAIL ill_rdata: got %h expected 0", bus.rsp_rdata_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL ill_no_mem_req: got %b expected 0", bus.mem_req_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL ill_stall_resp: got %b expected 0", bus.stall_o); end
        tick();
        checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b1) begin errors++; $display("FAIL ill_hold: got valid=%b err=%b expected valid=0 err=1", bus.rsp_valid_o, bus.rsp_err_o); end
    endtask

    task automatic test_illegal();
        run_illegal(1'b0, 3'b010, 32'h0000_0102);
        run_illegal(1'b0, 3'b011, 32'h0000_0100);
        run_illegal(1'b1, 3'b100, 32'h0000_0100);
        run_illegal(1'b1, 3'b001, 32'h0000_0101);
    endtask

    task automatic test_gnt_delay();
        issue(1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_F00D);
        tick();
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0300) begin errors++; $display("FAIL gnt_delay_hold cyc%0d: got req=%b addr=%h expected req=1 addr=00000300", i, bus.mem_req_o, bus.mem_addr_o); end
            if (i == 3) bus.mem_gnt_i = 1'b1;
            tick();
        end
        bus.mem_gnt_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL gnt_delay_rsp: got valid=%b req=%b expected valid=1 req=0", bus.rsp_valid_o, bus.mem_req_o); end
        tick();
    endtask

    // Issues a load, grants it, and leaves the unit in its first WAIT cycle.
    task automatic load_to_wait(input logic [31:0] addr);
        issue(1'b0, 3'b010, addr, 32'd0);
        tick();
        bus.req_valid_i = 1'b0;
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
    endtask

    task automatic test_timeout();
        load_to_wait(32'h0000_0200);
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if (bus.rsp_valid_o !== 1'b0 || bus.stall_o !== 1'b1) begin errors++; $display("FAIL timeout_early wait%0d: got valid=%b stall=%b expected valid=0 stall=1", i + 2, bus.rsp_valid_o, bus.stall_o); end
        end
        tick();
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'd0) begin errors++; $display("FAIL timeout_rsp: got valid=%b err=%b rdata=%h expected 1 1 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555_5555;
        tick();
        bus.mem_rvalid_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL late_rvalid: got valid=%b ready=%b expected valid=0 ready=1", bus.rsp_valid_o, bus.req_ready_o); end
        // rvalid arriving in the final WAIT cycle must win over the timeout.
        load_to_wait(32'h0000_0204);
        for (int i = 0; i < 15; i++) tick();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h7654_3210;
        tick();
        bus.mem_rvalid_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rsp_rdata_o !== 32'h7654_3210) begin errors++; $display("FAIL rvalid_wins: got valid=%b err=%b rdata=%h expected 1 0 76543210", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        load_to_wait(32'h0000_0400);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.mem_req_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid: got req=%b valid=%b ready=%b expected 0 0 1", bus.mem_req_o, bus.rsp_valid_o, bus.req_ready_o); end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hAAAA_AAAA;
        tick();
        bus.mem_rvalid_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_rdata_o !== 32'd0) begin errors++; $display("FAIL rst_rvalid_ignored: got valid=%b rdata=%h expected 0 0", bus.rsp_valid_o, bus.rsp_rdata_o); end
    endtask

    task automatic test_back_to_back();
        // A new request presented in the IDLE cycle right after a response.
        run_store(3'b000, 32'h0000_0010, 32'h0000_003C, 32'h0000_0010, 4'b0001, 32'h3C3C_3C3C);
        run_load(3'b100, 32'h0000_0013, 32'hF100_0000, 32'h0000_00F1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stores();
        test_loads();
        test_illegal();
        test_gnt_delay();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
